// File: rtl/svm_sched_pkg.sv
// svm_sched_pkg: shared state encoding and counter widths for the batch scheduler
package svm_sched_pkg;
    localparam int BATCH_ID_W = 8;
    localparam int CNT_W = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        DRAIN = 2'b10
    } state_t;
endpackage

// File: rtl/dep_conflict_detect.sv
// dep_conflict_detect: flags write-after-read, read-after-write and write-after-write hazards against a batch
module dep_conflict_detect #(
    parameter int W = 256
) (
    input  logic [W-1:0] in_rd,
    input  logic [W-1:0] in_wr,
    input  logic [W-1:0] b_rd,
    input  logic [W-1:0] b_wr,
    output logic         conflict
);
    assign conflict = (|(in_wr & (b_rd | b_wr))) | (|(in_rd & b_wr));
endmodule

// File: rtl/batch_dispatch_ctrl.sv
// batch_dispatch_ctrl: packs non-conflicting transactions into batches and waits for completion between batches
module batch_dispatch_ctrl
    import svm_sched_pkg::*;
#(
    parameter int MAX_DEPENDENCIES = 256,
    parameter int MAX_BATCH_SIZE = 8,
    parameter int BATCH_TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [63:0]                 s_axis_tdata_owner_programID,
    input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
    input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [63:0]                 m_axis_tdata_owner_programID,
    output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_read_dependencies,
    output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_write_dependencies,
    output logic [BATCH_ID_W-1:0]       m_axis_tdata_batch_id,
    input  logic                        exec_done,
    output logic                        batch_closed,
    output logic [CNT_W-1:0]            batch_closed_size,
    output logic                        done_overflow,
    output logic [31:0]                 batches_dispatched
);
    state_t state, state_next;
    logic [MAX_DEPENDENCIES-1:0] b_rd, b_wr;
    logic [CNT_W-1:0] issued_cnt, done_cnt, idle_cnt;
    logic [BATCH_ID_W-1:0] batch_id;
    logic conflict, accept, full, close, drain_done;

    dep_conflict_detect #(.W(MAX_DEPENDENCIES)) u_conflict (
        .in_rd(s_axis_tdata_read_dependencies),
        .in_wr(s_axis_tdata_write_dependencies),
        .b_rd(b_rd),
        .b_wr(b_wr),
        .conflict(conflict)
    );

    assign full = issued_cnt == CNT_W'(MAX_BATCH_SIZE);
    assign s_axis_tready = (state == IDLE || state == FILL) && (!m_axis_tvalid || m_axis_tready)
                           && (issued_cnt < CNT_W'(MAX_BATCH_SIZE)) && !(s_axis_tvalid && conflict);
    assign accept = s_axis_tvalid && s_axis_tready;
    // a blocked conflicting txn, a full batch, or a long quiet spell all end the batch
    assign close = state == FILL && ((s_axis_tvalid && conflict) || full
                   || (idle_cnt == CNT_W'(BATCH_TIMEOUT - 1) && !accept));
    assign drain_done = state == DRAIN && !m_axis_tvalid && done_cnt == issued_cnt;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    end

    // next-state: open on first accept, close into drain, reopen once everything issued has completed
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = accept ? FILL : IDLE;
            FILL:    state_next = close ? DRAIN : FILL;
            DRAIN:   state_next = drain_done ? IDLE : DRAIN;
            default: state_next = IDLE;
        endcase
    end

    // batch masks, counters, output register and status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_rd <= '0;
            b_wr <= '0;
            issued_cnt <= '0;
            done_cnt <= '0;
            idle_cnt <= '0;
            batch_id <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata_owner_programID <= '0;
            m_axis_tdata_read_dependencies <= '0;
            m_axis_tdata_write_dependencies <= '0;
            m_axis_tdata_batch_id <= '0;
            batch_closed <= 1'b0;
            batch_closed_size <= '0;
            done_overflow <= 1'b0;
            batches_dispatched <= '0;
        end else begin
            batch_closed <= close;
            if (close) batch_closed_size <= issued_cnt;
            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata_owner_programID <= s_axis_tdata_owner_programID;
                m_axis_tdata_read_dependencies <= s_axis_tdata_read_dependencies;
                m_axis_tdata_write_dependencies <= s_axis_tdata_write_dependencies;
                m_axis_tdata_batch_id <= batch_id;
                b_rd <= b_rd | s_axis_tdata_read_dependencies;
                b_wr <= b_wr | s_axis_tdata_write_dependencies;
                issued_cnt <= issued_cnt + CNT_W'(1);
                idle_cnt <= '0;
            end else begin
                if (m_axis_tready) m_axis_tvalid <= 1'b0;
                if (state == FILL) idle_cnt <= idle_cnt + CNT_W'(1);
            end
            if (exec_done) begin
                if (done_cnt != issued_cnt) done_cnt <= done_cnt + CNT_W'(1);
                else done_overflow <= 1'b1;
            end
            if (drain_done) begin
                b_rd <= '0;
                b_wr <= '0;
                issued_cnt <= '0;
                done_cnt <= '0;
                idle_cnt <= '0;
                batch_id <= batch_id + BATCH_ID_W'(1);
                batches_dispatched <= batches_dispatched + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_batch_dispatch_ctrl.sv
// tb_batch_dispatch_ctrl: directed and random stimulus checked against a set-based batch model
module tb_batch_dispatch_ctrl;
    localparam int D = 256;
    localparam int MB = 8;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0, ed = 1'b0;
    logic [63:0] s_id = '0, m_id;
    logic [D-1:0] s_rd = '0, s_wr = '0, m_rd, m_wr;
    logic [7:0] m_bid, c_size;
    logic c_pulse, ovf;
    logic [31:0] disp;

    always #5 clk = ~clk;

    batch_dispatch_ctrl #(.MAX_DEPENDENCIES(D), .MAX_BATCH_SIZE(MB), .BATCH_TIMEOUT(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready),
        .s_axis_tdata_owner_programID(s_id),
        .s_axis_tdata_read_dependencies(s_rd),
        .s_axis_tdata_write_dependencies(s_wr),
        .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready),
        .m_axis_tdata_owner_programID(m_id),
        .m_axis_tdata_read_dependencies(m_rd),
        .m_axis_tdata_write_dependencies(m_wr),
        .m_axis_tdata_batch_id(m_bid),
        .exec_done(ed),
        .batch_closed(c_pulse),
        .batch_closed_size(c_size),
        .done_overflow(ovf),
        .batches_dispatched(disp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [D-1:0] got, input logic [D-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: a batch is an open set of read/write footprints plus issued/completed tallies
    bit open;
    int n_iss, n_done, idle, bid, ndisp, csz;
    bit cp, movf, mv;
    logic [D-1:0] brd, bwr, mrd, mwr;
    logic [63:0] mid;
    int mbid;

    logic last_rdy;
    int closed_seen, last_sz;

    function automatic logic [D-1:0] b(input int n);
        logic [D-1:0] v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic bit clash();
        return (|(s_wr & (brd | bwr))) || (|(s_rd & bwr));
    endfunction

    function automatic bit model_rdy();
        return open && (!mv || m_ready) && n_iss < MB && !(s_valid && clash());
    endfunction

    task automatic model_reset();
        open = 1; n_iss = 0; n_done = 0; idle = 0; bid = 0; ndisp = 0; csz = 0;
        cp = 0; movf = 0; mv = 0; brd = '0; bwr = '0; mrd = '0; mwr = '0; mid = '0; mbid = 0;
    endtask

    task automatic model_step();
        bit c, a, fill, cls, fin;
        c = clash();
        a = s_valid && model_rdy();
        fill = open && n_iss > 0;
        cls = fill && !a && ((s_valid && c) || n_iss == MB || idle == TO - 1);
        fin = !open && !mv && n_done == n_iss;
        cp = cls;
        if (cls) csz = n_iss;
        if (ed) begin
            if (n_done == n_iss) movf = 1;
            else n_done++;
        end
        if (a) begin
            mv = 1; mid = s_id; mrd = s_rd; mwr = s_wr; mbid = bid;
            brd |= s_rd; bwr |= s_wr; n_iss++; idle = 0;
        end else begin
            if (m_ready) mv = 0;
            if (fill) idle++;
        end
        if (cls) open = 0;
        if (fin) begin
            brd = '0; bwr = '0; n_iss = 0; n_done = 0; idle = 0;
            bid = (bid + 1) % 256; ndisp++; open = 1;
        end
    endtask

    task automatic cyc(input bit v, input logic [63:0] id, input logic [D-1:0] rd, input logic [D-1:0] wr,
                       input bit r, input bit e);
        @(negedge clk);
        rst_n = 1'b1; s_valid = v; s_id = id; s_rd = rd; s_wr = wr; m_ready = r; ed = e;
        #1;
        check("s_tready", s_ready, model_rdy());
        check("m_tvalid", m_valid, mv);
        check("m_id", m_id, mid);
        check("m_rd", m_rd, mrd);
        check("m_wr", m_wr, mwr);
        check("m_bid", m_bid, mbid);
        check("closed", c_pulse, cp);
        if (cp) check("closed_size", c_size, csz);
        check("overflow", ovf, movf);
        check("dispatched", disp, ndisp);
        last_rdy = s_ready;
        if (c_pulse) begin
            closed_seen++;
            last_sz = int'(c_size);
        end
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; s_valid = 0; m_ready = 0; ed = 0;
        model_reset();
        closed_seen = 0; last_sz = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, 1, 0);
    endtask

    task automatic wait_close(input int bound);
        for (int i = 0; i < bound && closed_seen == 0; i++) cyc(0, 0, '0, '0, 1, 0);
        check("close_seen", closed_seen != 0, 1);
    endtask

    function automatic logic [D-1:0] rdep(input int dens);
        logic [D-1:0] v = '0;
        int k;
        for (int i = 0; i < dens; i++) if ($urandom % 2 == 0) begin
            k = $urandom % 14;
            v |= b(k == 13 ? 255 : k);
        end
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();
        // three disjoint txns back-to-back, then the idle timeout closes the batch
        cyc(1, 1, b(0), b(8), 1, 0);
        cyc(1, 2, b(1), b(9), 1, 0);
        cyc(1, 3, b(2), b(10), 1, 0);
        wait_close(80);
        check("t1_size", last_sz, 3);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, 1, 1);
        idle_cycles(2);
        check("t1_disp", disp, 1);

        // read-after-write conflict holds B and closes the batch at size 1
        do_reset();
        cyc(1, 10, '0, b(5), 1, 0);
        cyc(1, 11, b(5), '0, 1, 0);
        check("t2_hold", last_rdy, 0);
        cyc(1, 11, b(5), '0, 1, 1);
        for (int i = 0; i < 10 && !last_rdy; i++) cyc(1, 11, b(5), '0, 1, 0);
        check("t2_acc", last_rdy, 1);
        cyc(0, 0, '0, '0, 1, 0);
        check("t2_size", last_sz, 1);
        check("t2_id", m_id, 11);
        check("t2_bid", m_bid, 1);

        // read-read overlap shares a batch
        do_reset();
        cyc(1, 20, b(7), '0, 1, 0);
        check("t3_a", last_rdy, 1);
        cyc(1, 21, b(7), '0, 1, 0);
        check("t3_b", last_rdy, 1);
        wait_close(80);
        check("t3_size", last_sz, 2);

        // ninth txn waits for the size-limited batch to drain
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 64'(30 + i), b(i), b(100 + i), 1, 0);
        cyc(1, 38, b(8), b(108), 1, 0);
        check("t4_full", last_rdy, 0);
        for (int i = 0; i < 8; i++) cyc(1, 38, b(8), b(108), 1, 1);
        for (int i = 0; i < 10 && !last_rdy; i++) cyc(1, 38, b(8), b(108), 1, 0);
        check("t4_acc", last_rdy, 1);
        cyc(0, 0, '0, '0, 1, 0);
        check("t4_size", last_sz, 8);
        check("t4_id", m_id, 38);
        check("t4_bid", m_bid, 1);

        // downstream stall: output holds, input blocked, drain waits for the output slot
        do_reset();
        cyc(1, 40, b(1), '0, 1, 0);
        cyc(1, 41, '0, b(1), 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 41, '0, b(1), 0, 0);
            check("t5_hold_id", m_id, 40);
            check("t5_blocked", last_rdy, 0);
            check("t5_no_disp", disp, 0);
        end
        idle_cycles(3);
        check("t5_disp", disp, 1);

        // spurious completion is sticky; reset mid-fill clears everything
        do_reset();
        cyc(1, 50, '0, b(2), 1, 0);
        cyc(1, 51, b(2), '0, 1, 0);
        cyc(0, 0, '0, '0, 1, 1);
        cyc(0, 0, '0, '0, 1, 1);
        idle_cycles(1);
        check("t6_ovf", ovf, 1);
        cyc(1, 52, b(3), '0, 1, 0);
        cyc(1, 53, b(4), '0, 1, 0);
        check("t6_ovf_sticky", ovf, 1);
        do_reset();
        cyc(0, 0, '0, '0, 1, 0);
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_bid", m_bid, 0);
        check("t6_rst_ovf", ovf, 0);

        // random traffic at several offered loads
        for (int ph = 0; ph < 6; ph++) begin
            do_reset();
            for (int i = 0; i < 1500; i++) begin
                int pv;
                bit e;
                pv = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 50 : 4;
                e = (n_iss > n_done && $urandom % 4 == 0) || ($urandom % 400 == 0);
                cyc($urandom % 100 < pv, {$urandom, $urandom}, rdep(2),
                    ($urandom % 3 == 0) ? rdep(1) : '0, $urandom % 4 != 0, e);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
